// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver (5-9 data bits, parity, 1-2 stop bits)
//
// Ports:
//   osc_clk       system clock, all logic on the rising edge
//   i_Rst         asynchronous active-high reset
//   i_Rx_Serial   asynchronous serial input, idle high
//   o_Rx_DV       one-cycle pulse when a frame completes
//   o_Rx_Byte     received data, first bit on the line is the LSB
//   o_Parity_Err  parity mismatch on the last frame
//   o_Frame_Err   a stop bit was sampled low on the last frame
//   o_Break       last frame was all zeros including parity and stop bits
//   o_Busy        high whenever the receiver is not in IDLE
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 osc_clk,
    input  logic                 i_Rst,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int H  = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(CLKS_PER_BIT - 3);
    localparam logic [CW-1:0] CNT_S1   = CW'(CLKS_PER_BIT - 2);
    localparam logic [CW-1:0] CNT_HALF = CW'(H);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_WAIT_IDLE = 3'd0,
        S_IDLE      = 3'd1,
        S_START     = 3'd2,
        S_DATA      = 3'd3,
        S_PAR       = 3'd4,
        S_STOP      = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t                 state, state_n;
    logic                   sync1, line;
    logic [CW-1:0]          cnt;
    logic [3:0]             bit_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   smp0, smp1;
    logic                   perr, ferr, nonzero, last_stop_zero;

    logic                   bit_val, bit_end, cnt_bad, idx_bad, counting;

    // 2-of-3 vote: two earlier captures plus the live line at the final count
    assign bit_val  = (smp0 & smp1) | (smp0 & line) | (smp1 & line);
    assign bit_end  = (cnt == CNT_LAST);
    assign counting = (state == S_START) || (state == S_DATA) ||
                      (state == S_PAR)   || (state == S_STOP);

    assign o_Rx_DV = (state == S_DONE);
    assign o_Busy  = (state != S_IDLE);

    always_comb begin
        cnt_bad = 1'b0;
        idx_bad = 1'b0;
        case (state)
            S_START:         cnt_bad = int'(cnt) > H;
            S_DATA: begin
                cnt_bad = int'(cnt) >= CLKS_PER_BIT;
                idx_bad = int'(bit_idx) >= DATA_BITS;
            end
            S_PAR:           cnt_bad = int'(cnt) >= CLKS_PER_BIT;
            S_STOP: begin
                cnt_bad = int'(cnt) >= CLKS_PER_BIT;
                idx_bad = int'(bit_idx) >= STOP_BITS;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            S_WAIT_IDLE: if (line) state_n = S_IDLE;
            S_IDLE:      if (!line) state_n = S_START;
            S_START:     if (cnt == CNT_HALF) state_n = line ? S_IDLE : S_DATA;
            S_DATA:      if (bit_end && bit_idx == LAST_DATA)
                             state_n = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:       if (bit_end) state_n = S_STOP;
            S_STOP:      if (bit_end && bit_idx == LAST_STOP) state_n = S_DONE;
            S_DONE:      state_n = last_stop_zero ? S_WAIT_IDLE : S_IDLE;
            default:     state_n = S_WAIT_IDLE;
        endcase
        if (cnt_bad || idx_bad) state_n = S_WAIT_IDLE;
    end

    always_ff @(posedge osc_clk or posedge i_Rst) begin
        if (i_Rst) begin
            state <= S_WAIT_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge osc_clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync1          <= 1'b1;
            line           <= 1'b1;
            cnt            <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            smp0           <= 1'b0;
            smp1           <= 1'b0;
            perr           <= 1'b0;
            ferr           <= 1'b0;
            nonzero        <= 1'b0;
            last_stop_zero <= 1'b0;
            o_Rx_Byte      <= '0;
            o_Parity_Err   <= 1'b0;
            o_Frame_Err    <= 1'b0;
            o_Break        <= 1'b0;
        end else begin
            sync1 <= i_Rx_Serial;
            line  <= sync1;

            if (cnt == CNT_S0) smp0 <= line;
            if (cnt == CNT_S1) smp1 <= line;

            if (state_n != state || !counting) begin
                cnt     <= '0;
                bit_idx <= '0;
            end else begin
                cnt <= bit_end ? '0 : cnt + CW'(1);
                if (bit_end) bit_idx <= bit_idx + 4'd1;
            end

            if (state == S_START && state_n == S_DATA) begin
                perr    <= 1'b0;
                ferr    <= 1'b0;
                nonzero <= 1'b0;
            end

            if (bit_end && !cnt_bad && !idx_bad) begin
                case (state)
                    S_DATA: begin
                        shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
                        nonzero <= nonzero | bit_val;
                    end
                    S_PAR: begin
                        perr    <= bit_val ^ (^shreg) ^ (PARITY == 1);
                        nonzero <= nonzero | bit_val;
                    end
                    S_STOP: begin
                        if (!bit_val) ferr <= 1'b1;
                        nonzero        <= nonzero | bit_val;
                        last_stop_zero <= !bit_val;
                    end
                    default: ;
                endcase
            end

            // Outputs load on the final stop decision so they are valid during DONE
            if (state == S_STOP && state_n == S_DONE) begin
                o_Rx_Byte    <= shreg;
                o_Parity_Err <= (PARITY != 0) && perr;
                o_Frame_Err  <= ferr | !bit_val;
                o_Break      <= !(nonzero | bit_val);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - randomized self-checking bench for uart_rx_cfg
module tb_uart_rx_cfg;

    localparam int C = 16;
    localparam int H = (C - 1) / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rx;
    logic [2:0] dv, perr, ferr, brk, busy;
    logic [7:0] byte0, byte1;
    logic [6:0] byte2;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .osc_clk(clk), .i_Rst(rst), .i_Rx_Serial(rx[0]), .o_Rx_DV(dv[0]), .o_Rx_Byte(byte0),
        .o_Parity_Err(perr[0]), .o_Frame_Err(ferr[0]), .o_Break(brk[0]), .o_Busy(busy[0]));
    uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
        .osc_clk(clk), .i_Rst(rst), .i_Rx_Serial(rx[1]), .o_Rx_DV(dv[1]), .o_Rx_Byte(byte1),
        .o_Parity_Err(perr[1]), .o_Frame_Err(ferr[1]), .o_Break(brk[1]), .o_Busy(busy[1]));
    uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_c (
        .osc_clk(clk), .i_Rst(rst), .i_Rx_Serial(rx[2]), .o_Rx_DV(dv[2]), .o_Rx_Byte(byte2),
        .o_Parity_Err(perr[2]), .o_Frame_Err(ferr[2]), .o_Break(brk[2]), .o_Busy(busy[2]));

    int nb_d [3] = '{8, 8, 7};
    int par_d[3] = '{0, 2, 1};
    int st_d [3] = '{1, 1, 2};

    typedef struct {
        int         dut;
        int         cyc;
        logic [8:0] data;
        bit         perr;
        bit         ferr;
        bit         brk;
        bit         lsz;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] h_data[3];
    bit         h_perr[3], h_ferr[3], h_brk[3];
    bit         busy_chk[3];
    int         last_dv[3];
    int         cyc = 0;
    int         vectors = 0;
    int         misc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int d, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            misc++;
            $display("FAIL %s dut%0d cyc=%0d got=0x%0h expected=0x%0h", nm, d, cyc, act, exp_v);
        end
    endtask

    // Per-cycle comparison of every receiver against the model
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            int         idx;
            bit         exp_dv;
            logic [8:0] act;
            idx = -1;
            for (int i = 0; i < exp_q.size(); i++)
                if (idx < 0 && exp_q[i].dut == d) idx = i;
            exp_dv = !rst && idx >= 0 && exp_q[idx].cyc == cyc;
            act = (d == 0) ? {1'b0, byte0} : (d == 1) ? {1'b0, byte1} : {2'b0, byte2};
            if (busy_chk[d]) begin
                check("busy_after_dv", d, int'(busy[d]), 0);
                busy_chk[d] = 1'b0;
            end
            check("dv", d, int'(dv[d]), int'(exp_dv));
            if (dv[d]) last_dv[d] = cyc;
            if (exp_dv) begin
                h_data[d]   = exp_q[idx].data;
                h_perr[d]   = exp_q[idx].perr;
                h_ferr[d]   = exp_q[idx].ferr;
                h_brk[d]    = exp_q[idx].brk;
                busy_chk[d] = !exp_q[idx].lsz;
                exp_q.delete(idx);
            end
            check("byte", d, int'(act), int'(h_data[d]));
            check("parity_err", d, int'(perr[d]), int'(h_perr[d]));
            check("frame_err", d, int'(ferr[d]), int'(h_ferr[d]));
            check("break", d, int'(brk[d]), int'(h_brk[d]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int d = 0; d < 3; d++) begin
            h_data[d] = '0; h_perr[d] = 0; h_ferr[d] = 0; h_brk[d] = 0; busy_chk[d] = 0;
        end
    endtask

    // Sends one frame on receiver d and queues the outcome the rules dictate.
    // fg_bit/fg_off force a one-cycle inverted glitch; rnd_gl adds at most one
    // random glitch per bit (never on the start bit or the final stop bit).
    task automatic send_frame(input int d, input logic [8:0] data, input bit bad_par,
                              input logic [1:0] stops, input bit rnd_gl,
                              input int fg_bit, input int fg_off,
                              input int low_bits, input int gap_bits, output int n0);
        logic       bits[$];
        logic       p;
        logic [8:0] dm;
        bit         allz;
        exp_t       e;
        int         gl;
        bits.push_back(1'b0);
        p  = (par_d[d] == 1);
        dm = '0;
        for (int i = 0; i < nb_d[d]; i++) begin
            bits.push_back(data[i]);
            p     = p ^ data[i];
            dm[i] = data[i];
        end
        if (par_d[d] != 0) bits.push_back(p ^ bad_par);
        for (int s = 0; s < st_d[d]; s++) bits.push_back(stops[s]);
        allz = 1;
        for (int i = 1; i < bits.size(); i++) if (bits[i]) allz = 0;
        n0     = cyc;
        e.dut  = d;
        e.cyc  = n0 + 4 + H + (bits.size() - 1) * C;
        e.data = dm;
        e.perr = (par_d[d] != 0) && bad_par;
        e.ferr = (stops[0] == 1'b0) || (st_d[d] == 2 && stops[1] == 1'b0);
        e.brk  = allz;
        e.lsz  = (stops[st_d[d]-1] == 1'b0);
        exp_q.push_back(e);
        for (int b = 0; b < bits.size(); b++) begin
            gl = -1;
            if (rnd_gl && b > 0 && b < bits.size() - 1 && $urandom_range(2) == 0)
                gl = $urandom_range(C - 1);
            if (b == fg_bit) gl = fg_off;
            for (int t = 0; t < C; t++) begin
                rx[d] = (t == gl) ? ~bits[b] : bits[b];
                tick();
            end
        end
        rx[d] = 1'b0;
        repeat (low_bits * C) tick();
        rx[d] = 1'b1;
        repeat (gap_bits * C) tick();
    endtask

    task automatic idle_glitch(input int d, input int len);
        rx[d] = 1'b0;
        repeat (len) tick();
        rx[d] = 1'b1;
        repeat (H + 8) tick();
        check("glitch_busy", d, int'(busy[d]), 0);
    endtask

    // 0xF0 on receiver 0, reset asserted inside data bit 3 (line low) and
    // released two cycles before that bit ends, still low
    task automatic reset_mid_frame();
        logic [9:0] bits;
        bits = {1'b1, 8'hF0, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int t = 0; t < C; t++) begin
                rx[0] = bits[b];
                if (b == 4 && t == 3) begin
                    rst = 1'b1;
                    clear_model();
                end
                if (b == 4 && t == 6) check("rst_busy", 0, int'(busy[0]), 1);
                if (b == 4 && t == C - 2) rst = 1'b0;
                tick();
            end
        end
        rx[0] = 1'b1;
        repeat (2 * C) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        for (int d = 0; d < 3; d++) last_dv[d] = -1;
        clear_model();
        rst = 1'b1;
        rx  = 3'b111;
        repeat (4) tick();
        check("reset_busy", 0, int'(busy), 7);
        check("reset_dv", 0, int'(dv), 0);
        check("reset_byte", 0, int'(byte0), 0);
        rst = 1'b0;
        repeat (6) tick();
        check("idle_busy", 0, int'(busy), 0);

        send_frame(0, 9'hA5, 0, 2'b11, 0, -1, 0, 0, 2, n0);
        check("a5_byte", 0, int'(byte0), 'hA5);
        check("a5_flags", 0, int'({perr[0], ferr[0], brk[0]}), 0);
        check("a5_latency", 0, last_dv[0] - n0, 155);

        send_frame(1, 9'h03, 0, 2'b11, 0, -1, 0, 0, 2, n0);
        check("par_ok_byte", 1, int'(byte1), 'h03);
        check("par_ok_err", 1, int'(perr[1]), 0);
        send_frame(1, 9'h03, 1, 2'b11, 0, -1, 0, 0, 2, n0);
        check("par_bad_err", 1, int'(perr[1]), 1);
        check("par_bad_latency", 1, last_dv[1] - n0, 171);

        send_frame(2, 9'h55, 0, 2'b01, 0, -1, 0, 0, 2, n0);
        check("stop2_byte", 2, int'(byte2), 'h55);
        check("stop2_ferr", 2, int'(ferr[2]), 1);
        send_frame(2, 9'h2A, 0, 2'b11, 0, -1, 0, 0, 2, n0);
        check("clean_byte", 2, int'(byte2), 'h2A);
        check("clean_ferr", 2, int'(ferr[2]), 0);
        check("c_latency", 2, last_dv[2] - n0, 171);

        send_frame(0, 9'h00, 0, 2'b00, 0, -1, 0, 2, 2, n0);
        check("break_flags", 0, int'({perr[0], ferr[0], brk[0]}), 3);
        check("break_byte", 0, int'(byte0), 0);
        send_frame(0, 9'h7E, 0, 2'b11, 0, -1, 0, 0, 2, n0);
        check("after_break", 0, int'({brk[0], byte0}), 'h7E);

        idle_glitch(0, 5);

        send_frame(0, 9'h00, 0, 2'b11, 0, 1, H, 0, 2, n0);
        check("glitch_byte", 0, int'(byte0), 0);

        reset_mid_frame();
        send_frame(0, 9'h81, 0, 2'b11, 0, -1, 0, 0, 2, n0);
        check("post_reset_byte", 0, int'(byte0), 'h81);

        for (int it = 0; it < 30; it++) begin
            int         d;
            logic [8:0] dat;
            logic [1:0] st;
            bit         bp;
            d      = $urandom_range(2);
            dat    = 9'($urandom);
            bp     = ($urandom_range(3) == 0);
            st[0]  = ($urandom_range(4) != 0);
            st[1]  = ($urandom_range(4) != 0);
            if ($urandom_range(4) == 0) idle_glitch(d, $urandom_range(H, 1));
            send_frame(d, dat, bp, st, 1, -1, 0, 0, $urandom_range(3, 1), n0);
        end

        repeat (20) tick();
        check("pending_frames", 0, exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
